// File: rtl/wb_rdwr_arbiter.sv
// Round-robin Wishbone arbiter for a read-bridge master (A) and a write-bridge master (B).
// A per-grant ack watchdog aborts a hung cycle and returns an error to the owning master.
module wb_rdwr_arbiter #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGDEPTH   = 4,
    parameter int LGTIMEOUT = 10
) (
    input  logic            i_clk,
    input  logic            w_reset,

    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,

    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,

    output logic [DW-1:0]   o_rdata,

    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data,

    output logic [7:0]      o_timeouts
);

    typedef enum logic [2:0] {IDLE, GNT_A, GNT_B, ABORT_A, ABORT_B} state_t;

    localparam logic [LGTIMEOUT-1:0] WDOG_MAX = '1;
    localparam logic [LGTIMEOUT-1:0] WDOG_ONE = LGTIMEOUT'(1);
    localparam logic [LGDEPTH-1:0]   PEND_MAX = '1;
    localparam logic [LGDEPTH-1:0]   PEND_ONE = LGDEPTH'(1);

    state_t               state;
    logic                 last_b;
    logic [LGDEPTH-1:0]   npending;
    logic [LGTIMEOUT-1:0] wdog;
    logic                 granted;
    logic                 timeout;
    logic                 beat;

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        case (state)
            GNT_A: begin
                o_wb_cyc = i_a_cyc;
                o_wb_stb = i_a_cyc && i_a_stb;
            end
            GNT_B: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = i_b_cyc && i_b_stb;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_wb_sel  = i_b_sel;
            end
            default: ;
        endcase
    end

    assign granted = (state == GNT_A) || (state == GNT_B);
    // A same-cycle ack or slave error takes precedence over the watchdog.
    assign timeout = granted && o_wb_cyc && (wdog == WDOG_MAX) && !i_wb_ack && !i_wb_err;
    assign beat    = o_wb_stb && !i_wb_stall;
    assign o_rdata = i_wb_data;

    always_comb begin
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        if (!w_reset) begin
            case (state)
                GNT_A: begin
                    o_a_stall = i_wb_stall;
                    o_a_ack   = i_wb_ack;
                    o_a_err   = i_wb_err || timeout;
                end
                GNT_B: begin
                    o_b_stall = i_wb_stall;
                    o_b_ack   = i_wb_ack;
                    o_b_err   = i_wb_err || timeout;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            npending   <= '0;
            wdog       <= '0;
            o_timeouts <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_a_cyc && (!i_b_cyc || last_b)) begin
                        state  <= GNT_A;
                        last_b <= 1'b0;
                    end else if (i_b_cyc) begin
                        state  <= GNT_B;
                        last_b <= 1'b1;
                    end
                end
                GNT_A: begin
                    if (timeout) begin
                        state <= ABORT_A;
                    end else if (!i_a_cyc) begin
                        if (i_b_cyc) begin
                            state  <= GNT_B;
                            last_b <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT_B: begin
                    if (timeout) begin
                        state <= ABORT_B;
                    end else if (!i_b_cyc) begin
                        if (i_a_cyc) begin
                            state  <= GNT_A;
                            last_b <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ABORT_A: if (!i_a_cyc) state <= IDLE;
                ABORT_B: if (!i_b_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!o_wb_cyc || i_wb_err)
                npending <= '0;
            else if (beat && !i_wb_ack && (npending != PEND_MAX))
                npending <= npending + PEND_ONE;
            else if (i_wb_ack && !beat && (npending != '0))
                npending <= npending - PEND_ONE;

            // Any grant change passes through a cyc-low cycle or a timeout, both of which clear.
            if (!o_wb_cyc || i_wb_ack || i_wb_err || timeout)
                wdog <= '0;
            else if (npending != '0)
                wdog <= wdog + WDOG_ONE;

            if (timeout && (o_timeouts != 8'hff))
                o_timeouts <= o_timeouts + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_rdwr_arbiter.sv
// Directed bench for wb_rdwr_arbiter with a short watchdog (LGTIMEOUT=4).
module tb_wb_rdwr_arbiter;
    localparam int AW = 26;
    localparam int DW = 32;

    logic            i_clk = 1'b0;
    logic            w_reset;
    logic            i_a_cyc, i_a_stb, i_a_we;
    logic [AW-1:0]   i_a_addr;
    logic [DW-1:0]   i_a_data;
    logic [DW/8-1:0] i_a_sel;
    logic            o_a_stall, o_a_ack, o_a_err;
    logic            i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0]   i_b_addr;
    logic [DW-1:0]   i_b_data;
    logic [DW/8-1:0] i_b_sel;
    logic            o_b_stall, o_b_ack, o_b_err;
    logic [DW-1:0]   o_rdata;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0]   i_wb_data;
    logic [7:0]      o_timeouts;

    int n_checks = 0;
    int n_fail   = 0;

    wb_rdwr_arbiter #(.AW(AW), .DW(DW), .LGDEPTH(4), .LGTIMEOUT(4)) dut (
        .i_clk(i_clk), .w_reset(w_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
        .i_a_data(i_a_data), .i_a_sel(i_a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_data(i_b_data), .i_b_sel(i_b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
        .o_rdata(o_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data),
        .o_timeouts(o_timeouts)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        w_reset = 1;
        step();
        step();
        w_reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int acks, beats, peak, nerr, first;

        do_reset();
        #1;
        check_eq("rst_outputs", {o_wb_cyc, o_wb_stb, o_a_stall, o_b_stall, o_a_ack, o_a_err, o_b_ack, o_b_err},
                 8'b0011_0000);
        check_eq("rst_counters", {dut.npending, dut.wdog, o_timeouts}, '0);

        // single read from A
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 26'h10;
        #1;
        check_eq("t1_latency", o_wb_cyc, 0);
        check_eq("t1_idle_addr", o_wb_addr, 26'h10);
        step(); #1;
        check_eq("t1_grant", {o_wb_cyc, o_wb_stb, o_a_stall, o_b_stall}, 4'b1101);
        step();
        i_a_stb = 0;
        acks = 0;
        #1; acks += int'(o_a_ack);
        step();
        #1; acks += int'(o_a_ack);
        step();
        i_wb_ack = 1; i_wb_data = 32'hDEADBEEF;
        #1;
        acks += int'(o_a_ack);
        check_eq("t1_pending", dut.npending, 1);
        check_eq("t1_rdata", o_rdata, 32'hDEADBEEF);
        check_eq("t1_b_quiet", {o_b_ack, o_b_err, o_b_stall}, 3'b001);
        step();
        i_wb_ack = 0;
        #1;
        acks += int'(o_a_ack);
        check_eq("t1_ack_pulse", acks, 1);
        check_eq("t1_pending_zero", dut.npending, 0);
        i_a_cyc = 0;
        step(); step();

        // round-robin
        do_reset();
        i_a_cyc = 1; i_b_cyc = 1;
        #1;
        check_eq("t2_latency", o_wb_cyc, 0);
        step(); #1;
        check_eq("t2_a_first", {o_wb_cyc, o_a_stall, o_b_stall}, 3'b101);
        i_a_cyc = 0;
        #1;
        check_eq("t2_gap", {o_wb_cyc, o_b_stall}, 2'b01);
        step();
        i_a_cyc = 1;
        #1;
        check_eq("t2_b_grant", {o_wb_cyc, o_a_stall, o_b_stall}, 3'b110);
        step(); #1;
        check_eq("t2_a_waits", {o_a_stall, o_b_stall}, 2'b10);
        i_b_cyc = 0;
        #1;
        check_eq("t2_gap_b", o_wb_cyc, 0);
        step(); #1;
        check_eq("t2_a_next", {o_wb_cyc, o_a_stall, o_b_stall}, 3'b101);
        i_a_cyc = 0;
        step();
        i_a_cyc = 1; i_b_cyc = 1;
        step(); #1;
        check_eq("t2_tie_b", {o_wb_cyc, o_a_stall, o_b_stall}, 3'b110);
        i_a_cyc = 0; i_b_cyc = 0;
        step();

        // pipelined burst from B, slave stalls every other cycle
        i_b_cyc = 1; i_b_stb = 1; i_b_we = 1; i_b_addr = 26'h2A0; i_b_data = 32'hCAFE0001; i_b_sel = 4'hF;
        step();
        beats = 0; peak = 0;
        for (int i = 0; i < 8; i++) begin
            i_wb_stall = (i % 2 == 0);
            #1;
            if (o_wb_stb && !o_b_stall) beats++;
            if (i == 1)
                check_eq("t3_bus_mux", {o_wb_we, o_wb_sel, o_wb_addr, o_wb_data},
                         {1'b1, 4'hF, 26'h2A0, 32'hCAFE0001});
            step();
            if (int'(dut.npending) > peak) peak = int'(dut.npending);
        end
        i_b_stb = 0; i_wb_stall = 0;
        #1;
        check_eq("t3_beats", beats, 4);
        check_eq("t3_peak", peak, 4);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            i_wb_ack = 1;
            #1;
            acks += int'(o_b_ack);
            step();
        end
        i_wb_ack = 0;
        #1;
        check_eq("t3_acks", acks, 4);
        check_eq("t3_pending_zero", dut.npending, 0);
        i_b_cyc = 0; i_b_we = 0;
        step(); step();

        // watchdog expiry on A
        i_a_cyc = 1; i_a_stb = 1; i_a_addr = 26'h44;
        step();
        step();
        i_a_stb = 0;
        nerr = 0; first = -1;
        for (int cnt = 0; cnt < 20; cnt++) begin
            #1;
            if (o_a_err) begin
                nerr++;
                if (first < 0) first = cnt;
            end
            step();
        end
        #1;
        check_eq("t4_err_cycle", first, 15);
        check_eq("t4_err_once", nerr, 1);
        check_eq("t4_aborted", {o_wb_cyc, o_wb_stb, o_a_stall}, 3'b001);
        check_eq("t4_timeouts", o_timeouts, 1);
        i_wb_ack = 1;
        #1;
        check_eq("t4_late_ack", {o_a_ack, o_a_err, o_b_ack}, 3'b000);
        step();
        i_wb_ack = 0; i_a_cyc = 0;
        step();
        i_a_cyc = 1;
        step(); #1;
        check_eq("t4_recover", {o_wb_cyc, o_a_stall}, 2'b10);
        i_a_cyc = 0;
        step(); step();

        // slave error on B write
        i_b_cyc = 1; i_b_stb = 1; i_b_we = 1; i_b_addr = 26'h80; i_b_data = 32'h12345678;
        step();
        step();
        i_b_stb = 0;
        #1;
        check_eq("t5_pending", dut.npending, 1);
        i_wb_err = 1;
        #1;
        check_eq("t5_err_route", {o_b_err, o_a_err, o_b_ack}, 3'b100);
        step();
        i_wb_err = 0;
        #1;
        check_eq("t5_after", {o_b_err, o_wb_cyc, dut.npending}, {1'b0, 1'b1, 4'd0});
        check_eq("t5_timeouts", o_timeouts, 1);
        i_b_cyc = 0; i_b_we = 0;
        step(); step();

        // reset in the middle of a burst
        i_b_cyc = 1; i_b_stb = 1;
        step();
        step();
        step();
        i_b_stb = 0;
        #1;
        check_eq("t6_pending", dut.npending, 2);
        w_reset = 1;
        step(); #1;
        check_eq("t6_outputs", {o_wb_cyc, o_a_stall, o_b_stall, o_a_ack, o_a_err, o_b_ack, o_b_err},
                 7'b0110000);
        check_eq("t6_counters", {dut.npending, dut.wdog, o_timeouts}, '0);
        w_reset = 0; i_b_cyc = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
